// File: rtl/key_router_n.sv
`default_nettype none
// ---- key_router_n : sync/debounce UP+MODE keys, route UP pulses (with auto-repeat) to mode ----
// ---- rev 1.0                                                                                ----
module key_router_n #(
  parameter int N_MODES       = 5,
  parameter int MODE_W        = 3,
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_key_up,
  input  logic               i_key_mode,
  input  logic               i_on_off,
  output logic [N_MODES-1:0] o_up,
  output logic [N_MODES-1:0] o_select,
  output logic [MODE_W-1:0]  o_mode,
  output logic               o_active
);

  localparam int C_DW   = $clog2(DEB_CYCLES + 1);
  localparam int C_HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_HW   = $clog2(C_HMAX + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_RPT = 2'd2} state_t;

  // Bit 0 carries the UP key, bit 1 the MODE key.
  logic [1:0]      w_raw;
  logic [1:0]      r_s1, r_s2, r_deb, r_deb_d;
  logic [C_DW-1:0] r_dcnt [2];
  logic            r_on_s1, r_on_s2;

  state_t              r_state, w_state_nxt;
  logic [C_HW-1:0]     r_hcnt, w_hcnt_nxt;
  logic [MODE_W-1:0]   r_mode, w_mode_nxt;
  logic [N_MODES-1:0]  r_up, w_up_nxt, r_sel, w_sel_nxt;
  logic                w_en, w_up_press, w_mode_press, w_fire;

  assign w_raw = {i_key_mode, i_key_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_on_s1 <= 1'b0;
      r_on_s2 <= 1'b0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_on_s1 <= i_on_off;
      r_on_s2 <= r_on_s1;
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_deb[i]) begin
          if (r_dcnt[i] == C_DW'(DEB_CYCLES - 1)) begin
            r_deb[i]  <= r_s2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + C_DW'(1);
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  // Outputs are all registered off the value 'active' takes at this edge, so they move with it.
  assign w_en         = r_on_s1;
  assign w_up_press   = r_deb[0] & ~r_deb_d[0];
  assign w_mode_press = w_en & r_deb[1] & ~r_deb_d[1];

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_fire      = 1'b0;
    if (!w_en) begin
      w_state_nxt = S_IDLE;
    end else if (w_up_press) begin
      w_fire      = 1'b1;
      w_hcnt_nxt  = '0;
      w_state_nxt = (w_mode_press || REPEAT_DELAY == 0) ? S_IDLE : S_HOLD;
    end else if (w_mode_press || !r_deb[0]) begin
      // Only a fresh debounced press can leave idle, so idle doubles as "repeat cancelled".
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_hcnt == C_HW'(REPEAT_DELAY - 1)) begin
            w_fire      = 1'b1;
            w_hcnt_nxt  = '0;
            w_state_nxt = S_RPT;
          end else begin
            w_hcnt_nxt = r_hcnt + C_HW'(1);
          end
        end
        S_RPT: begin
          if (r_hcnt == C_HW'(REPEAT_PERIOD - 1)) begin
            w_fire     = 1'b1;
            w_hcnt_nxt = '0;
          end else begin
            w_hcnt_nxt = r_hcnt + C_HW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (!w_en)             w_mode_nxt = '0;
    else if (w_mode_press) w_mode_nxt = (r_mode == MODE_W'(N_MODES - 1)) ? '0 : r_mode + MODE_W'(1);
    else                   w_mode_nxt = r_mode;

    w_sel_nxt = w_en   ? (N_MODES'(1) << w_mode_nxt) : '0;
    w_up_nxt  = w_fire ? (N_MODES'(1) << r_mode)     : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_mode  <= '0;
      r_sel   <= '0;
      r_up    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_mode  <= w_mode_nxt;
      r_sel   <= w_sel_nxt;
      r_up    <= w_up_nxt;
    end
  end

  assign o_up     = r_up;
  assign o_select = r_sel;
  assign o_mode   = r_mode;
  assign o_active = r_on_s2;

endmodule
`default_nettype wire

// File: tb/tb_key_router_n.sv
`default_nettype none
// ---- tb_key_router_n : directed + random stimulus against a cycle-level reference model ----
// ---- rev 1.0                                                                             ----
module tb_key_router_n;
  localparam int N = 5, MW = 3, DEB = 4, RD = 16, RP = 4, HSZ = 4100;

  logic          clk = 1'b0;
  logic          rst;
  logic          k_up, k_mode, on;
  logic [N-1:0]  up, sel;
  logic [MW-1:0] mode;
  logic          act;

  always #5 clk = ~clk;

  key_router_n #(.N_MODES(N), .MODE_W(MW), .DEB_CYCLES(DEB),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .i_key_up(k_up), .i_key_mode(k_mode), .i_on_off(on),
    .o_up(up), .o_select(sel), .o_mode(mode), .o_active(act));

  int n_chk = 0, n_fail = 0, n_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: histories indexed by edge number + 2 so early edges read zeros.
  bit ru[HSZ], rm[HSZ], ro[HSZ], du[HSZ], dm[HSZ];
  int k, runu, runm, m_mode, m_p;
  bit m_live;
  logic [31:0] e_up, e_sel, e_mode, e_act;

  task automatic model_reset();
    for (int i = 0; i < HSZ; i++) begin
      ru[i] = 0; rm[i] = 0; ro[i] = 0; du[i] = 0; dm[i] = 0;
    end
    k = 0; runu = 0; runm = 0; m_mode = 0; m_p = 0; m_live = 0;
  endtask

  task automatic model_edge();
    int b;
    bit en, pu, pm, fire;
    b    = k + 2;
    en   = ro[b-1];
    pu   = du[b-1] && !du[b-2];
    pm   = dm[b-1] && !dm[b-2] && en;
    fire = 0;
    if (en && pu) begin
      fire = 1; m_p = k; m_live = !pm && (RD > 0);
    end else if (!en || pm || !du[b-1]) begin
      m_live = 0;
    end else if (m_live && (k - m_p) >= RD && ((k - m_p - RD) % RP) == 0) begin
      fire = 1;
    end
    e_up   = fire ? (32'd1 << m_mode) : 32'd0;
    m_mode = en ? (pm ? (m_mode + 1) % N : m_mode) : 0;
    e_sel  = en ? (32'd1 << m_mode) : 32'd0;
    e_mode = m_mode;
    e_act  = en;
    if (ru[b-2] != du[b-1]) begin
      runu++;
      du[b] = (runu == DEB) ? ru[b-2] : du[b-1];
      if (runu == DEB) runu = 0;
    end else begin
      runu = 0; du[b] = du[b-1];
    end
    if (rm[b-2] != dm[b-1]) begin
      runm++;
      dm[b] = (runm == DEB) ? rm[b-2] : dm[b-1];
      if (runm == DEB) runm = 0;
    end else begin
      runm = 0; dm[b] = dm[b-1];
    end
  endtask

  task automatic step();
    if (k + 4 >= HSZ) begin
      $display("FAIL hist_overflow: got %0d expected below %0d", k, HSZ - 4);
      $fatal(1);
    end
    ru[k+3] = k_up; rm[k+3] = k_mode; ro[k+3] = on;
    @(posedge clk);
    k++;
    model_edge();
    #1;
    chk("up", up, e_up);
    chk("select", sel, e_sel);
    chk("mode", mode, e_mode);
    chk("active", act, e_act);
    if (up != '0) n_pulse++;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic press_mode();
    k_mode = 1; hold(8); k_mode = 0; hold(8);
  endtask

  int lat;

  initial begin
    rst = 1; k_up = 0; k_mode = 0; on = 0;
    #23;
    chk("rst_up", up, 0); chk("rst_sel", sel, 0); chk("rst_mode", mode, 0); chk("rst_act", act, 0);
    rst = 0;
    model_reset();
    on = 1; hold(5);
    press_mode(); press_mode();
    chk("mode_is_2", mode, 2);

    // Clean press: pulse on channel 2 exactly DEB+3 edges after the raw edge.
    k_up = 1; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (up != '0 && lat == 0) begin
        lat = i;
        chk("press_val", up, 5'b00100);
      end
    end
    chk("press_lat", lat, DEB + 3);
    k_up = 0; hold(10);

    // Short glitch is filtered.
    n_pulse = 0;
    k_up = 1; hold(2); k_up = 0; hold(12);
    chk("glitch_pulses", n_pulse, 0);

    // Mode walk 0..4 and wrap.
    press_mode(); press_mode(); press_mode();
    chk("mode_is_0", mode, 0);
    for (int i = 1; i <= 5; i++) begin
      press_mode();
      chk("mode_walk", mode, i % N);
      chk("sel_walk", sel, 32'd1 << (i % N));
    end

    // Hold 40 cycles at mode 0: pulses at press, +16, +20, ... +36.
    n_pulse = 0;
    k_up = 1; hold(40); k_up = 0; hold(15);
    chk("repeat_pulses", n_pulse, 7);

    // Simultaneous press at mode 4: one pulse to mode 4, mode wraps, no repeat.
    press_mode(); press_mode(); press_mode(); press_mode();
    chk("mode_is_4", mode, 4);
    n_pulse = 0;
    k_up = 1; k_mode = 1; hold(10);
    chk("simul_mode", mode, 0);
    k_mode = 0; hold(30);
    chk("simul_pulses", n_pulse, 1);
    k_up = 0; hold(10);

    // Disable while held at mode 3, re-enable while held, then re-press.
    press_mode(); press_mode(); press_mode();
    k_up = 1; hold(12);
    on = 0; hold(4);
    chk("off_sel", sel, 0); chk("off_mode", mode, 0);
    n_pulse = 0;
    on = 1; hold(30);
    chk("reenable_pulses", n_pulse, 0);
    k_up = 0; hold(10);
    k_up = 1; hold(10);
    chk("repress_pulses", n_pulse, 1);

    // Asynchronous reset while UP is held.
    #3 rst = 1;
    #1;
    chk("arst_up", up, 0); chk("arst_sel", sel, 0); chk("arst_mode", mode, 0); chk("arst_act", act, 0);
    #2 rst = 0;
    model_reset();
    n_pulse = 0;
    hold(20);
    chk("held_thru_rst", n_pulse, 1);

    // Random segments.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 15) == 0) on = ~on;
      k_up   = 1'($urandom_range(0, 1));
      k_mode = ($urandom_range(0, 3) == 0);
      hold($urandom_range(1, 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
